// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-timing helpers.
// Also used by the transmitter in main_module.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_t;

    // Clock cycles per bit period. Integer division truncates,
    // which gives 86 at 10 MHz / 115200.
    function automatic int calc_clks_per_bit(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

    // Offset from the start-bit edge to its midpoint.
    function automatic int calc_half(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for the UART receiver.
// Circular buffer whose pointers carry one extra wrap bit so that the
// full and empty conditions can be told apart. The head entry is always
// visible on pop_data.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;
    logic                  wr_en;
    logic                  rd_en;

    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // When full, a write is only possible because the head leaves this cycle.
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; cleared on reset so the head output reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers, wrapping naturally through the extra bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with a small receive FIFO.
// The serial line is synchronized, then sampled mid-bit by a
// START/DATA/STOP state machine; good bytes are pushed into uart_rx_fifo.
// Optional feature macro: UART_RX_PARITY_EN enables an even-parity bit
// after the data bits, checked in the PARITY state.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_SPEED = 10000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rtx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  parity_err_o
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_SPEED, BAUD_RATE);
    localparam int HALF         = calc_half(CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    logic                  sync_meta_r;
    logic                  rx_sync_r;
    uart_state_t           state_r, state_n;
    logic [CNT_W-1:0]      cnt_r, cnt_n;
    logic [BIT_W-1:0]      bit_r, bit_n;
    logic [DATA_WIDTH-1:0] shift_r, shift_n;
    logic                  push_s;
    logic                  frame_err_s;
    logic                  frame_err_r;
    logic                  overrun_r;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad_r, par_bad_n;
    logic                  parity_err_s;
    logic                  parity_err_r;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            rx_sync_r   <= 1'b1;
        end else begin
            sync_meta_r <= rtx;
            rx_sync_r   <= sync_meta_r;
        end
    end

    // Receiver state, timing counter, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= '0;
            shift_r <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= par_bad_n;
`endif
        end
    end

    // Next-state logic: mid-bit sampling, glitch rejection, framing checks.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        bit_n       = bit_r;
        shift_n     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad_r;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                if (!rx_sync_r) begin
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_W'(HALF - 1)) begin
                    cnt_n = '0;
                    // A line that is high again at mid-start was only a glitch.
                    if (!rx_sync_r) begin
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync_r, shift_r[DATA_WIDTH-1:1]};
                    bit_n   = bit_r + BIT_W'(1);
                    if (bit_r == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    if (rx_sync_r != even_parity(shift_r)) begin
                        par_bad_n    = 1'b1;
                        parity_err_s = 1'b1;
                    end else begin
                        par_bad_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_r == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n = '0;
                    if (rx_sync_r) begin
`ifdef UART_RX_PARITY_EN
                        push_s = !par_bad_r;
`else
                        push_s = 1'b1;
`endif
                        state_n = IDLE;
                    end else begin
                        // Low stop bit: drop the byte and wait out any break.
                        frame_err_s = 1'b1;
                        state_n     = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_r) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_HIGH;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase
    end

    assign valid_o = !fifo_empty_s;
    assign pop_s   = valid_o && ready_i;

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= frame_err_s;
            overrun_r   <= push_s && fifo_full_s && !pop_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Registered parity error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_s;
        end
    end
    assign parity_err_o = parity_err_r;
`else
    assign parity_err_o = 1'b0;
`endif

    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .pop_data  (data_o),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: stimulus pushes expected bytes,
// a negedge monitor pops and compares whenever valid_o && ready_i.
// Honors UART_RX_PARITY_EN for frame format and the parity test.
module tb_uart_rx_buffered;
    import uart_pkg::*;

    localparam int CPB = 86;

    logic       clk = 1'b0;
    logic       rst;
    logic       rtx;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int first_valid_cyc = -1;
    logic [7:0] exp_q[$];

    uart_rx_buffered dut (
        .clk          (clk),
        .rst          (rst),
        .rtx          (rtx),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts output activity and scores every accepted byte.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (valid_o) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (frame_err_o)  ferr_cnt++;
            if (overrun_o)    ovr_cnt++;
            if (parity_err_o) perr_cnt++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0h, expected no byte", data_o);
                end else begin
                    check("pop_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int n);
        rtx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic ep(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len, input logic par_b);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b, CPB);
`endif
        drive_bit(stop_b, stop_len);
        drive_bit(1'b1, 20);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b1, CPB, ep(d));
    endtask

    initial begin
        int base_v;
        int base_f;
        int base_o;
        int base_p;
        int c0;
        rst = 1'b1;
        rtx = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        check("rst_perr", {31'd0, parity_err_o}, 32'd0);
        rst = 1'b0;
        drive_bit(1'b1, 10);

        // 0xA5: one-cycle valid close to the stop-bit midpoint.
        base_v = valid_cnt;
        first_valid_cyc = -1;
        c0 = cyc;
        exp_q.push_back(8'hA5);
        send(8'hA5);
        check("a5_valid_cycles", valid_cnt - base_v, 32'd1);
        check("a5_latency_ok", {31'd0, (first_valid_cyc - c0 >= 817) && (first_valid_cyc - c0 <= 821)}, 32'd1);
        check("a5_q_empty", exp_q.size(), 32'd0);

        // 20-cycle low glitch: no output, back to IDLE.
        base_v = valid_cnt;
        base_f = ferr_cnt;
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 200);
        check("glitch_valid", valid_cnt - base_v, 32'd0);
        check("glitch_ferr", ferr_cnt - base_f, 32'd0);
        check("glitch_idle", {29'd0, dut.state_r}, {29'd0, IDLE});

        // 0x3C with low stop held for 300 cycles, then 0x11.
        base_f = ferr_cnt;
        send_frame(8'h3C, 1'b0, 300, ep(8'h3C));
        drive_bit(1'b1, 100);
        check("break_ferr", ferr_cnt - base_f, 32'd1);
        exp_q.push_back(8'h11);
        send(8'h11);
        check("break_ferr_once", ferr_cnt - base_f, 32'd1);
        check("break_q_empty", exp_q.size(), 32'd0);

        // Overrun: stall the consumer, five bytes into four entries.
        ready_i = 1'b0;
        base_o = ovr_cnt;
        for (int i = 1; i <= 4; i++) send(i[7:0]);
        check("ovr_none_yet", ovr_cnt - base_o, 32'd0);
        send(8'h05);
        check("ovr_pulse", ovr_cnt - base_o, 32'd1);
        check("ovr_hold_valid", {31'd0, valid_o}, 32'd1);
        check("ovr_hold_data", {24'd0, data_o}, 32'd1);
        for (int i = 1; i <= 4; i++) exp_q.push_back(i[7:0]);
        ready_i = 1'b1;
        drive_bit(1'b1, 10);
        check("ovr_drained", exp_q.size(), 32'd0);
        check("ovr_valid_low", {31'd0, valid_o}, 32'd0);

        // Reset during bit 4 of 0xFF with a byte pending, then 0x5A.
        ready_i = 1'b0;
        send(8'hC3);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
        drive_bit(1'b1, 40);
        rst = 1'b1;
        drive_bit(1'b1, 3);
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_data", {24'd0, data_o}, 32'd0);
        check("mid_rst_flags", {29'd0, frame_err_o, overrun_o, parity_err_o}, 32'd0);
        rst = 1'b0;
        ready_i = 1'b1;
        drive_bit(1'b1, CPB - 43 + 3 * CPB + CPB);
        base_v = valid_cnt;
        exp_q.push_back(8'h5A);
        send(8'h5A);
        check("rst_only_5a", valid_cnt - base_v, 32'd1);
        check("rst_q_empty", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 needs parity bit 1.
        base_p = perr_cnt;
        base_v = valid_cnt;
        send_frame(8'h07, 1'b1, CPB, 1'b0);
        check("par_err_pulse", perr_cnt - base_p, 32'd1);
        check("par_no_push", valid_cnt - base_v, 32'd0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, CPB, 1'b1);
        check("par_ok_once", perr_cnt - base_p, 32'd1);
        check("par_q_empty", exp_q.size(), 32'd0);
`else
        base_p = 0;
        check("perr_tied_low", perr_cnt - base_p, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line rate in bit/s.
REQ-003 SHALL have parameter CLOCK_SPEED, default 10000000: clk frequency in Hz.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rtx, input, 1: serial line; asynchronous to clk; idles high.
REQ-008 SHALL have port data_o, output, DATA_WIDTH: FIFO head byte.
REQ-009 SHALL have port valid_o, output, 1: data_o holds a byte.
REQ-010 SHALL have port ready_i, input, 1: the consumer (main_module command path) accepts the head byte.
REQ-011 SHALL have port frame_err_o, output, 1: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun_o, output, 1: one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-013 SHALL have port parity_err_o, output, 1: one-cycle pulse on a parity mismatch.

Function
REQ-014 SHALL pass rtx through a 2-flop synchronizer reset to 1; all decisions SHALL use the synchronized value.
REQ-015 SHALL define CLKS_PER_BIT = CLOCK_SPEED/BAUD_RATE, truncated (86 at defaults), and HALF = CLKS_PER_BIT/2 (43).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-017 IDLE SHALL move to START when synced rtx==0, and SHALL clear the bit counter.
REQ-018 START SHALL resample after HALF cycles; rtx==0 goes to DATA, and rtx==1 counts as a glitch and returns to IDLE with no output.
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, LSB first, and SHALL leave after DATA_WIDTH samples (to PARITY if enabled, else STOP).
REQ-020 STOP SHALL sample once.
  - rtx==1: push the byte and go to IDLE.
  - rtx==0: discard the byte, pulse frame_err_o and go to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL return to IDLE only once synced rtx==1, so a break condition never retriggers.
REQ-022 valid_o SHALL be 1 whenever the FIFO is non-empty; a pop SHALL occur on any cycle where valid_o && ready_i.
REQ-023 After a push into an empty FIFO, valid_o and data_o SHALL update on the next clk edge.
REQ-024 A push while full without a simultaneous pop SHALL drop the new byte, keep the stored data and pulse overrun_o.
REQ-025 A push and a pop in the same cycle while full SHALL both be accepted; the occupancy is unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-027 data_o SHALL hold its value while valid_o && !ready_i.

Reset
REQ-028 rst SHALL asynchronously force the following:
  - FSM to IDLE;
  - counters, the shift register and FIFO pointers to 0;
  - synchronizer flops to 1;
  - valid_o, frame_err_o, overrun_o and parity_err_o to 0;
  - data_o to 0.
REQ-029 rst asserted mid-frame SHALL abandon the frame; after release, the remaining bits SHALL be treated as line activity (REQ-017/018) and SHALL NOT produce output unless they form a valid frame.

Configuration
REQ-030 With UART_RX_PARITY_EN defined, a PARITY state SHALL sample one even-parity bit after DATA; on a mismatch it SHALL discard the byte, pulse parity_err_o and still proceed to STOP.
REQ-031 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent and parity_err_o SHALL be tied 0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum and the CLKS_PER_BIT/HALF computation; main_module's UART transmitter SHALL reuse it.
REQ-033 The FIFO SHALL be a sub-module, uart_rx_fifo (parameters DATA_WIDTH and FIFO_DEPTH; push/pop/full/empty).

Verification
REQ-034 The bench SHALL drive frame 0xA5 (86 clk/bit, ready_i=1) and check data_o=0xA5 with valid_o high for exactly 1 cycle, within 3 cycles of the stop-bit midpoint.
REQ-035 The bench SHALL drive a 20-cycle low glitch on rtx and check no valid_o, no frame_err_o, and the FSM back in IDLE.
REQ-036 The bench SHALL drive 0x3C with stop bit 0, held low for 300 cycles, then 0x11; it SHALL check one frame_err_o pulse, no push for 0x3C, and data_o=0x11 delivered.
REQ-037 The bench SHALL hold ready_i=0 and send 0x01..0x05; it SHALL check overrun_o pulsed on 0x05, then ready_i=1 pops 0x01,0x02,0x03,0x04 in order and then valid_o=0.
REQ-038 The bench SHALL assert rst during bit 4 of 0xFF, then send 0x5A; it SHALL check all outputs 0 in reset and only 0x5A received.
REQ-039 With UART_RX_PARITY_EN defined, the bench SHALL send 0x07 with parity bit 0; it SHALL check one parity_err_o pulse and no push, and that 0x07 with parity bit 1 is pushed.
